// File: rtl/rsc_dec_obuffer.sv
// rsc_dec_obuffer: two-bank ping-pong output buffer for the RSC decoder.
// The writer fills one bank while the reader drains the other. Each bank also
// carries a block error count and a block tag.
// Optional feature: define RSC_DEC_OBUF_DERR_EN to store per-word error flags.
module rsc_dec_obuffer #(
  parameter int unsigned pADDR_W = 8,
  parameter int unsigned pDAT_W  = 2,
  parameter int unsigned pDTAG_W = 8,
  parameter int unsigned pTAG_W  = 8
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               iwrite,
  input  logic [pADDR_W-1:0] iwaddr,
  input  logic [pDAT_W-1:0]  iwdata,
  input  logic [pDAT_W-1:0]  iwderr,
  input  logic [pDTAG_W-1:0] iwdtag,
  input  logic               iwfull,
  input  logic [15:0]        iwerr,
  input  logic [pTAG_W-1:0]  iwtag,
  output logic               owbusy,
  input  logic               irempty,
  input  logic [pADDR_W-1:0] iraddr,
  output logic               ofull,
  output logic [pDAT_W-1:0]  ordata,
  output logic [pDAT_W-1:0]  orderr,
  output logic [pDTAG_W-1:0] ordtag,
  output logic [15:0]        oerr,
  output logic [pTAG_W-1:0]  otag
);

`ifdef RSC_DEC_OBUF_DERR_EN
  localparam int unsigned WordW = pDTAG_W + 2 * pDAT_W;
`else
  localparam int unsigned WordW = pDTAG_W + pDAT_W;
`endif
  localparam int unsigned Words = 2 ** (pADDR_W + 1);

  logic [WordW-1:0]  mem [Words];
  logic [WordW-1:0]  wword;
  logic [WordW-1:0]  rword_q;

  logic [1:0]        cnt_q, cnt_d;
  logic              wbank_q, rbank_q;
  logic              full_q, busy_q;
  logic [15:0]       err_q [2];
  logic [pTAG_W-1:0] tag_q [2];

  logic              wfull_acc, rempty_acc, wr_en;

`ifdef RSC_DEC_OBUF_DERR_EN
  assign wword  = {iwdtag, iwderr, iwdata};
  assign ordtag = rword_q[WordW-1 -: pDTAG_W];
  assign orderr = rword_q[2*pDAT_W-1 -: pDAT_W];
  assign ordata = rword_q[pDAT_W-1:0];
`else
  logic unused_derr;
  assign unused_derr = ^iwderr;
  assign wword  = {iwdtag, iwdata};
  assign ordtag = rword_q[WordW-1 -: pDTAG_W];
  assign orderr = '0;
  assign ordata = rword_q[pDAT_W-1:0];
`endif

  assign wfull_acc  = iwfull && (cnt_q != 2'd2);
  assign rempty_acc = irempty && (cnt_q != 2'd0);
  // Writes into a full buffer would land in the reader's bank, so drop them.
  assign wr_en      = iclkena && ireset && iwrite && (cnt_q != 2'd2);

  // Occupancy next state: simultaneous accept and release cancel out.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({wfull_acc, rempty_acc})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Bank pointers, occupancy, status flags and per-bank block registers.
  always_ff @(posedge iclk) begin
    if (!ireset) begin
      cnt_q   <= 2'd0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q[0] <= '0;
      err_q[1] <= '0;
      tag_q[0] <= '0;
      tag_q[1] <= '0;
    end else if (iclkena) begin
      cnt_q  <= cnt_d;
      full_q <= (cnt_d != 2'd0);
      busy_q <= (cnt_d == 2'd2);
      if (wfull_acc) begin
        err_q[wbank_q] <= iwerr;
        tag_q[wbank_q] <= iwtag;
        wbank_q        <= ~wbank_q;
      end
      if (rempty_acc) begin
        rbank_q <= ~rbank_q;
      end
    end
  end

  // Word storage; contents survive reset.
  always_ff @(posedge iclk) begin
    if (wr_en) begin
      mem[{wbank_q, iwaddr}] <= wword;
    end
  end

  // Registered read port, one cycle from iraddr.
  always_ff @(posedge iclk) begin
    if (!ireset) begin
      rword_q <= '0;
    end else if (iclkena) begin
      rword_q <= mem[{rbank_q, iraddr}];
    end
  end

  assign ofull  = full_q;
  assign owbusy = busy_q;
  assign oerr   = err_q[rbank_q];
  assign otag   = tag_q[rbank_q];

endmodule

// File: tb/tb_rsc_dec_obuffer.sv
// Directed self-checking bench for rsc_dec_obuffer (default parameters).
module tb_rsc_dec_obuffer;

  logic        iclk = 1'b0;
  logic        ireset, iclkena, iwrite, iwfull, irempty;
  logic [7:0]  iwaddr, iraddr, iwdtag, iwtag;
  logic [1:0]  iwdata, iwderr;
  logic [15:0] iwerr;
  logic        owbusy, ofull;
  logic [1:0]  ordata, orderr;
  logic [7:0]  ordtag, otag;
  logic [15:0] oerr;

  int n_checks = 0;
  int n_errors = 0;

  rsc_dec_obuffer dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .iwrite  (iwrite),
    .iwaddr  (iwaddr),
    .iwdata  (iwdata),
    .iwderr  (iwderr),
    .iwdtag  (iwdtag),
    .iwfull  (iwfull),
    .iwerr   (iwerr),
    .iwtag   (iwtag),
    .owbusy  (owbusy),
    .irempty (irempty),
    .iraddr  (iraddr),
    .ofull   (ofull),
    .ordata  (ordata),
    .orderr  (orderr),
    .ordtag  (ordtag),
    .oerr    (oerr),
    .otag    (otag)
  );

  always #5 iclk = ~iclk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [1:0] d, input logic [7:0] t);
    iwrite = 1'b1; iwaddr = a; iwdata = d; iwdtag = t; iwderr = 2'b11;
    tick();
    iwrite = 1'b0;
  endtask

  task automatic close_block(input logic [15:0] e, input logic [7:0] t);
    iwfull = 1'b1; iwerr = e; iwtag = t;
    tick();
    iwfull = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [1:0] d,
                          input logic [7:0] t);
    logic [1:0] exp_derr;
`ifdef RSC_DEC_OBUF_DERR_EN
    exp_derr = 2'b11;
`else
    exp_derr = 2'b00;
`endif
    iraddr = a;
    tick();
    check_eq({tag, "_dat"}, 32'(ordata), 32'(d));
    check_eq({tag, "_dtag"}, 32'(ordtag), 32'(t));
    check_eq({tag, "_derr"}, 32'(orderr), 32'(exp_derr));
  endtask

  initial begin
    logic [7:0] k8;
    ireset = 1'b0; iclkena = 1'b1; iwrite = 1'b0; iwfull = 1'b0; irempty = 1'b0;
    iwaddr = '0; iraddr = '0; iwdata = '0; iwderr = '0; iwdtag = '0; iwerr = '0; iwtag = '0;
    tick(); tick();
    check_eq("rst_ofull", 32'(ofull), 0);
    check_eq("rst_owbusy", 32'(owbusy), 0);
    check_eq("rst_ordata", 32'(ordata), 0);
    check_eq("rst_ordtag", 32'(ordtag), 0);
    check_eq("rst_oerr", 32'(oerr), 0);
    check_eq("rst_otag", 32'(otag), 0);
    ireset = 1'b1;

    // Block A into bank 0: dat = addr[1:0], dtag = addr ^ 5A.
    for (int k = 0; k < 256; k++) begin
      k8 = 8'(k);
      write_word(k8, k8[1:0], k8 ^ 8'h5A);
    end
    check_eq("a_pre_ofull", 32'(ofull), 0);
    close_block(16'h0005, 8'hA1);
    check_eq("a_ofull", 32'(ofull), 1);
    check_eq("a_owbusy", 32'(owbusy), 0);
    check_eq("a_oerr", 32'(oerr), 32'h5);
    check_eq("a_otag", 32'(otag), 32'hA1);
    read_chk("a_rd0", 8'd0, 2'd0, 8'h5A);
    read_chk("a_rd7", 8'd7, 2'd3, 8'h5D);
    read_chk("a_rd254", 8'd254, 2'd2, 8'hA4);

    // Block B into bank 1: dat = ~addr[1:0], dtag = addr + 1.
    for (int k = 0; k < 8; k++) begin
      k8 = 8'(k);
      write_word(k8, ~k8[1:0], k8 + 8'd1);
    end
    close_block(16'h0007, 8'hB2);
    check_eq("b_owbusy", 32'(owbusy), 1);
    check_eq("b_ofull", 32'(ofull), 1);
    check_eq("b_otag_still_a", 32'(otag), 32'hA1);

    // Full: writes and a third close must be dropped.
    for (int k = 0; k < 4; k++) write_word(8'(k), 2'd0, 8'hFF);
    close_block(16'h00EE, 8'hC3);
    check_eq("c_owbusy", 32'(owbusy), 1);
    check_eq("c_otag", 32'(otag), 32'hA1);
    read_chk("c_rd_a1", 8'd1, 2'd1, 8'h5B);
    read_chk("c_rd_a2", 8'd2, 2'd2, 8'h58);

    // Release A; B becomes visible and must be uncorrupted.
    irempty = 1'b1; tick(); irempty = 1'b0;
    check_eq("r1_ofull", 32'(ofull), 1);
    check_eq("r1_owbusy", 32'(owbusy), 0);
    check_eq("r1_otag", 32'(otag), 32'hB2);
    check_eq("r1_oerr", 32'(oerr), 32'h7);
    read_chk("r1_rd_b2", 8'd2, 2'd1, 8'h03);
    read_chk("r1_rd_b0", 8'd0, 2'd3, 8'h01);

    // cnt=1: simultaneous close and release.
    write_word(8'd9, 2'd2, 8'h99);
    iwfull = 1'b1; irempty = 1'b1; iwerr = 16'h0009; iwtag = 8'hD4;
    tick();
    iwfull = 1'b0; irempty = 1'b0;
    check_eq("s_ofull", 32'(ofull), 1);
    check_eq("s_owbusy", 32'(owbusy), 0);
    check_eq("s_otag", 32'(otag), 32'hD4);
    check_eq("s_oerr", 32'(oerr), 32'h9);
    read_chk("s_rd9", 8'd9, 2'd2, 8'h99);

    // Drain, then release at cnt=0 must be ignored.
    irempty = 1'b1; tick();
    check_eq("e_ofull", 32'(ofull), 0);
    tick(); irempty = 1'b0;
    check_eq("e2_ofull", 32'(ofull), 0);
    check_eq("e2_owbusy", 32'(owbusy), 0);
    // Pointers now both at bank 1; a stray rbank toggle would show D4 here.
    close_block(16'h0011, 8'hE5);
    check_eq("e3_ofull", 32'(ofull), 1);
    check_eq("e3_owbusy", 32'(owbusy), 0);
    check_eq("e3_otag", 32'(otag), 32'hE5);
    close_block(16'h0012, 8'hF6);
    check_eq("e4_owbusy", 32'(owbusy), 1);

    // Reset with two blocks buffered.
    ireset = 1'b0; tick(); ireset = 1'b1;
    check_eq("x_ofull", 32'(ofull), 0);
    check_eq("x_owbusy", 32'(owbusy), 0);
    check_eq("x_otag", 32'(otag), 0);
    check_eq("x_oerr", 32'(oerr), 0);
    write_word(8'd5, 2'd3, 8'h55);
    close_block(16'h0017, 8'h17);
    check_eq("x2_ofull", 32'(ofull), 1);
    check_eq("x2_otag", 32'(otag), 32'h17);
    read_chk("x2_rd5", 8'd5, 2'd3, 8'h55);

    // Clock enable low freezes the close; high accepts it.
    iclkena = 1'b0;
    close_block(16'h0028, 8'h28);
    check_eq("g_owbusy_frozen", 32'(owbusy), 0);
    check_eq("g_ofull_frozen", 32'(ofull), 1);
    iclkena = 1'b1;
    close_block(16'h0028, 8'h28);
    check_eq("g_owbusy", 32'(owbusy), 1);
    check_eq("g_otag", 32'(otag), 32'h17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rsc_dec_obuffer.md
RSC_DEC_OBUFFER -- requirements
Module: rsc_dec_obuffer

Interface
REQ-001 SHALL have parameters: pADDR_W, default 8, per-bank word address width; pDAT_W, default 2, data width; pDTAG_W, default 8, per-word tag width; pTAG_W, default 8, per-block tag width.
REQ-002 SHALL use one clock and a synchronous, active-low reset; all state advances only when iclkena=1.
REQ-003 Ports, listed as name, direction, width, meaning:
- iclk  in  1  clock
- ireset  in  1  synchronous active-low reset
- iclkena  in  1  clock enable
- iwrite  in  1  write strobe
- iwaddr  in  pADDR_W  write word address
- iwdata  in  pDAT_W  decoded duobits
- iwderr  in  pDAT_W  bit error flags
- iwdtag  in  pDTAG_W  word tag
- iwfull  in  1  writer bank complete
- iwerr  in  16  block error count
- iwtag  in  pTAG_W  block tag
- owbusy  out  1  no free bank; the writer holds off
- irempty  in  1  reader releases its bank
- iraddr  in  pADDR_W  read word address
- ofull  out  1  read bank holds a block
- ordata  out  pDAT_W  read data
- orderr  out  pDAT_W  read error flags
- ordtag  out  pDTAG_W  read word tag
- oerr  out  16  error count of the read bank
- otag  out  pTAG_W  block tag of the read bank

Function
REQ-004 SHALL implement a 2-bank ping-pong buffer of 2^pADDR_W words per bank, each word holding {dtag, derr, dat}.
REQ-005 SHALL keep a write bank pointer wbank, a read bank pointer rbank (1 bit each) and an occupancy count cnt (0..2).
REQ-006 When iwrite=1, SHALL write the word at address {wbank, iwaddr}.
REQ-007 When iwfull=1 and cnt<2, SHALL capture iwerr/iwtag into the per-bank registers of wbank, toggle wbank and increment cnt, all effective on the next cycle.
REQ-008 When irempty=1 and cnt>0, SHALL toggle rbank and decrement cnt on the next cycle.
REQ-009 Simultaneous accepted iwfull and irempty: both pointers SHALL toggle and cnt SHALL stay unchanged.
REQ-010 Boundaries: iwfull at cnt=2 SHALL be ignored (no capture, no toggle); irempty at cnt=0 SHALL be ignored; iwrite at cnt=2 SHALL be discarded.
REQ-011 SHALL drive ofull = (cnt!=0) and owbusy = (cnt==2) as registered state, with no combinational path from iwfull or irempty.
REQ-012 The read path SHALL fetch address {rbank, iraddr}, with ordata/orderr/ordtag registered: 1-cycle latency from iraddr.
REQ-013 oerr/otag SHALL be combinationally muxed from the per-bank registers selected by rbank, valid whenever ofull=1.
REQ-014 Writer and reader SHALL always address different banks while cnt=1; no read-during-write hazard on one bank arises.
REQ-015 An accepted iwfull at cnt=0 SHALL raise ofull exactly 1 cycle later, and the bank contents SHALL be readable from that cycle.
REQ-016 iclkena=0 SHALL freeze all registers and block memory writes.

Reset
REQ-017 While ireset=0 at a clock edge: cnt=0, wbank=0, rbank=0, ofull=0, owbusy=0, ordata/orderr/ordtag=0, per-bank err/tag registers=0.
REQ-018 Memory contents SHALL NOT be reset.
REQ-019 Reset mid-operation SHALL discard all buffered blocks, and the next block SHALL be written to bank 0.

Configuration
REQ-020 Macro RSC_DEC_OBUF_DERR_EN: when defined, derr is stored and returned on orderr.
REQ-021 Without RSC_DEC_OBUF_DERR_EN: word width is reduced to {dtag, dat}, iwderr is ignored, and orderr is constant 0.

Verification
REQ-022 Write bank 0 with words 0..255 where dat=addr[1:0], then pulse iwfull with iwerr=16'h0005, iwtag=8'hA1 -> ofull=1 after 1 cycle; reading addr k returns k[1:0] 1 cycle later; oerr=5; otag=A1.
REQ-023 Fill two blocks with no irempty -> owbusy=1; a third iwfull is ignored (cnt stays 2); iwrite data does not corrupt either bank.
REQ-024 Pulse iwfull and irempty together at cnt=1 -> wbank and rbank both toggle, ofull stays 1, and otag switches to the second block's tag.
REQ-025 Pulse irempty at cnt=0 -> no state change, ofull stays 0; pulse ireset=0 at cnt=2 -> ofull=0, owbusy=0, and the next block lands in bank 0.
REQ-026 Hold iclkena=0 during an iwfull pulse -> no state change; repeat with iclkena=1 -> the pulse is accepted.
REQ-027 Build without RSC_DEC_OBUF_DERR_EN, write iwderr=2'b11 -> orderr reads 0 while ordata/ordtag stay correct.
